// File: rtl/debug_dump_ctrl_if.sv
// Word stream leaving the debug dump controller: one captured register per
// beat, tagged with its source address and a last-word marker.
interface debug_dump_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_addr,
    output out_last,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_addr,
    input  out_last,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/debug_dump_ctrl.sv
// Freezes the CPU, sweeps its debug read port over every register and streams
// each captured word out on a valid/ready interface.
module debug_dump_ctrl #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 64,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  debug_dump_ctrl_if.master out_if
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HOLD = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [3:0]        LAT_LOAD  = 4'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t     state_reg;
  logic [3:0] lat_cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg        <= IDLE;
      lat_cnt_reg      <= '0;
      debug_addr       <= '0;
      cpu_hold         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      out_if.out_data  <= '0;
      out_if.out_addr  <= '0;
      out_if.out_last  <= 1'b0;
      out_if.out_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over everything in the active states, including a
      // handshake landing on the same edge: that word is simply dropped.
      if (abort && (state_reg == HOLD || state_reg == WAIT || state_reg == SEND)) begin
        state_reg        <= IDLE;
        debug_addr       <= '0;
        cpu_hold         <= 1'b0;
        busy             <= 1'b0;
        out_if.out_valid <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              state_reg  <= HOLD;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
              debug_addr <= '0;
            end
          end
          HOLD: begin
            state_reg   <= WAIT;
            lat_cnt_reg <= LAT_LOAD;
          end
          WAIT: begin
            if (lat_cnt_reg != 4'd0) begin
              lat_cnt_reg <= lat_cnt_reg - 4'd1;
            end else begin
              state_reg        <= SEND;
              out_if.out_data  <= debug_data;
              out_if.out_addr  <= debug_addr;
              out_if.out_last  <= (debug_addr == LAST_ADDR);
              out_if.out_valid <= 1'b1;
            end
          end
          SEND: begin
            if (out_if.out_ready) begin
              out_if.out_valid <= 1'b0;
              if (out_if.out_last) begin
                state_reg <= DONE;
                done      <= 1'b1;
              end else begin
                // The address only advances here, so the last address never
                // wraps even when NUM_REGS fills the whole address space.
                state_reg   <= WAIT;
                debug_addr  <= debug_addr + 1'b1;
                lat_cnt_reg <= LAT_LOAD;
              end
            end
          end
          DONE: begin
            state_reg  <= IDLE;
            busy       <= 1'b0;
            cpu_hold   <= 1'b0;
            debug_addr <= '0;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
